// File: rtl/trace_record_assembler.sv
// Collects per-stage start/end timestamps for up to DEPTH in-flight instructions
// and releases each finished trace record in allocation order over valid/ready.
module trace_record_assembler #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int TIME_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int TAG_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [DATA_WIDTH-1:0]   alloc_instr,
  input  logic [ADDR_WIDTH-1:0]   alloc_addr,
  input  logic                    alloc_pass_through,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [2:0]              evt_valid,
  input  logic [3*TAG_W-1:0]      evt_tag,
  input  logic [2:0]              evt_end,
  input  logic                    if_end_valid,
  input  logic [TAG_W-1:0]        if_end_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_pass_through,
  output logic [8*TIME_WIDTH-1:0] out_times,
  output logic [15:0]             err_count,
  output logic [TIME_WIDTH-1:0]   now
);

  logic [DEPTH-1:0]      slot_valid, slot_complete, slot_pt;
  logic [DATA_WIDTH-1:0] slot_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] slot_addr  [DEPTH];
  logic [TIME_WIDTH-1:0] slot_times [DEPTH][8];
  logic [TAG_W-1:0]      head, tail;
  logic [TIME_WIDTH-1:0] counter;

  logic                  alloc_fire, pop;
  logic [TAG_W-1:0]      stage_tag [3];
  logic [2:0]            evt_ok;
  logic                  if_ok;
  logic [2:0]            bad_cnt;
  logic [16:0]           err_sum;

  assign now         = counter;
  assign alloc_ready = ~(&slot_valid);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign out_valid        = slot_valid[head] & slot_complete[head];
  assign out_instr        = slot_instr[head];
  assign out_addr         = slot_addr[head];
  assign out_pass_through = slot_pt[head];
  assign pop              = out_valid & out_ready;

  always_comb begin
    out_times = '0;
    for (int j = 0; j < 8; j++)
      out_times[(7-j)*TIME_WIDTH +: TIME_WIDTH] = slot_times[head][j];
  end

  // The slot being allocated this cycle is still invalid, so events to it are rejected.
  always_comb begin
    bad_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      stage_tag[i] = evt_tag[i*TAG_W +: TAG_W];
      evt_ok[i]    = evt_valid[i] & slot_valid[stage_tag[i]];
      bad_cnt      = bad_cnt + {2'b00, evt_valid[i] & ~evt_ok[i]};
    end
    if_ok   = if_end_valid & slot_valid[if_end_tag];
    bad_cnt = bad_cnt + {2'b00, if_end_valid & ~if_ok};
  end

  assign err_sum = {1'b0, err_count} + {14'b0, bad_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      err_count <= '0;
      head      <= '0;
      tail      <= '0;
      // NOTE: record storage is reset too, so out_* read as zero after reset.
      for (int d = 0; d < DEPTH; d++) begin
        slot_valid[d]    <= 1'b0;
        slot_complete[d] <= 1'b0;
        slot_pt[d]       <= 1'b0;
        slot_instr[d]    <= '0;
        slot_addr[d]     <= '0;
        for (int j = 0; j < 8; j++) slot_times[d][j] <= '0;
      end
    end else begin
      counter   <= counter + 1'b1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (flush) begin
        head <= '0;
        tail <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          slot_valid[d]    <= 1'b0;
          slot_complete[d] <= 1'b0;
          slot_pt[d]       <= 1'b0;
          slot_instr[d]    <= '0;
          slot_addr[d]     <= '0;
          for (int j = 0; j < 8; j++) slot_times[d][j] <= '0;
        end
      end else begin
        if (if_ok) begin
          slot_times[if_end_tag][1] <= counter;
          if (slot_pt[if_end_tag]) slot_complete[if_end_tag] <= 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
          if (evt_ok[i] && !slot_pt[stage_tag[i]]) begin
            slot_times[stage_tag[i]][{2'(i + 1), evt_end[i]}] <= counter;
            if (i == 2 && evt_end[i]) slot_complete[stage_tag[i]] <= 1'b1;
          end
        end
        if (alloc_fire) begin
          slot_valid[tail]    <= 1'b1;
          slot_complete[tail] <= 1'b0;
          slot_pt[tail]       <= alloc_pass_through;
          slot_instr[tail]    <= alloc_instr;
          slot_addr[tail]     <= alloc_addr;
          slot_times[tail][0] <= counter;
          for (int j = 1; j < 8; j++) slot_times[tail][j] <= '0;
          tail <= tail + 1'b1;
        end
        // NOTE: the pop is written last so its clear wins over same-cycle events to the head.
        if (pop) begin
          slot_valid[head]    <= 1'b0;
          slot_complete[head] <= 1'b0;
          slot_pt[head]       <= 1'b0;
          slot_instr[head]    <= '0;
          slot_addr[head]     <= '0;
          for (int j = 0; j < 8; j++) slot_times[head][j] <= '0;
          head <= head + 1'b1;
        end
      end
    end
  end

endmodule
